// File: rtl/dpram_pkg.sv
// Shared widths and types for the dual-port packet buffer RAM.
package dpram_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 128;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/dpram_port.sv
// One access port of the RAM.
// Decodes enable/write into read and write strobes and owns the
// registered read-data output, which is cleared asynchronously by reset.
module dpram_port
    import dpram_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  enable,
    input  logic  write,
    input  data_t read_word,
    output logic  write_en,
    output data_t data_out
);

    logic read_en;

    // Decode the access type; write is only meaningful when the port is enabled.
    always_comb begin
        read_en  = enable && !write;
        write_en = enable && write;
    end

    // Capture the addressed word on a read; otherwise hold the last read value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (read_en) begin
            data_out <= read_word;
        end
    end

endmodule

// File: rtl/dpram.sv
// True dual-port synchronous RAM used as the shared packet/data buffer.
// Both ports share one clock and one storage array. When both ports write
// the same word on the same edge, port A's data is kept. A read that
// coincides with a write to the same word returns the old contents,
// because the array is sampled before the non-blocking update lands.
module dpram
    import dpram_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  enable_port_a,
    input  logic  write_port_a,
    input  addr_t address_port_a,
    input  data_t data_in_port_a,
    output data_t data_out_port_a,
    input  logic  enable_port_b,
    input  logic  write_port_b,
    input  addr_t address_port_b,
    input  data_t data_in_port_b,
    output data_t data_out_port_b
);

    data_t mem [DEPTH];

    data_t read_word_a;
    data_t read_word_b;
    logic  write_en_a;
    logic  write_en_b;

    // Present the currently stored words to both ports' read registers.
    always_comb begin
        read_word_a = mem[address_port_a];
        read_word_b = mem[address_port_b];
    end

    // Update the array; B is applied first so that A overrides it on a
    // same-address collision. Nothing is written while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (write_en_b) begin
                mem[address_port_b] <= data_in_port_b;
            end
            if (write_en_a) begin
                mem[address_port_a] <= data_in_port_a;
            end
        end
    end

    dpram_port u_port_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable_port_a),
        .write     (write_port_a),
        .read_word (read_word_a),
        .write_en  (write_en_a),
        .data_out  (data_out_port_a)
    );

    dpram_port u_port_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable_port_b),
        .write     (write_port_b),
        .read_word (read_word_b),
        .write_en  (write_en_b),
        .data_out  (data_out_port_b)
    );

endmodule

// File: tb/tb_dpram.sv
// Directed self-checking bench for the dual-port RAM.
// Inputs change on the falling edge; outputs are checked on the falling
// edge after the rising edge that consumed the request.
module tb_dpram;
    import dpram_pkg::*;

    logic  clk;
    logic  rst_n;
    logic  enable_port_a;
    logic  write_port_a;
    addr_t address_port_a;
    data_t data_in_port_a;
    data_t data_out_port_a;
    logic  enable_port_b;
    logic  write_port_b;
    addr_t address_port_b;
    data_t data_in_port_b;
    data_t data_out_port_b;

    int total;
    int bad;

    localparam data_t V_PATTERN = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam data_t V_AAAA    = {8{16'hAAAA}};
    localparam data_t V_1111    = {32{4'h1}};
    localparam data_t V_2222    = {32{4'h2}};
    localparam data_t V_3333    = {32{4'h3}};
    localparam data_t V_4444    = {32{4'h4}};
    localparam data_t V_DEAD    = {4{32'hDEAD_BEEF}};
    localparam data_t V_X       = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
    localparam data_t V_Y       = 128'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    localparam data_t V_W       = 128'hCAFE_F00D_0000_0001_0000_0002_0000_0003;

    dpram dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_port_a   (enable_port_a),
        .write_port_a    (write_port_a),
        .address_port_a  (address_port_a),
        .data_in_port_a  (data_in_port_a),
        .data_out_port_a (data_out_port_a),
        .enable_port_b   (enable_port_b),
        .write_port_b    (write_port_b),
        .address_port_b  (address_port_b),
        .data_in_port_b  (data_in_port_b),
        .data_out_port_b (data_out_port_b)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of requests on both ports, then wait for the edge to
    // take effect and return on the following falling edge.
    task automatic applyStimulus(
        input logic  en_a, input logic we_a, input addr_t addr_a, input data_t din_a,
        input logic  en_b, input logic we_b, input addr_t addr_b, input data_t din_b
    );
        enable_port_a  = en_a;
        write_port_a   = we_a;
        address_port_a = addr_a;
        data_in_port_a = din_a;
        enable_port_b  = en_b;
        write_port_b   = we_b;
        address_port_b = addr_b;
        data_in_port_b = din_b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input data_t observed, input data_t expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        enable_port_a  = 1'b0;
        write_port_a   = 1'b0;
        address_port_a = '0;
        data_in_port_a = '0;
        enable_port_b  = 1'b0;
        write_port_b   = 1'b0;
        address_port_b = '0;
        data_in_port_b = '0;

        @(negedge clk);
        checkOutput("reset_a", data_out_port_a, '0);
        checkOutput("reset_b", data_out_port_b, '0);
        rst_n = 1'b1;

        $display("[TB] single-port write/read");
        applyStimulus(1, 1, 16'h0010, V_PATTERN, 0, 0, 16'h0000, '0);
        checkOutput("no_write_through_a", data_out_port_a, '0);
        applyStimulus(1, 0, 16'h0010, '0, 0, 0, 16'h0000, '0);
        checkOutput("read_a_0010", data_out_port_a, V_PATTERN);
        checkOutput("b_unchanged", data_out_port_b, '0);

        $display("[TB] cross-port");
        applyStimulus(1, 1, 16'hFFFF, V_AAAA, 0, 0, 16'h0000, '0);
        applyStimulus(0, 0, 16'h0000, '0, 1, 0, 16'hFFFF, '0);
        checkOutput("cross_b_ffff", data_out_port_b, V_AAAA);
        checkOutput("cross_a_hold", data_out_port_a, V_PATTERN);

        $display("[TB] write collision");
        applyStimulus(1, 1, 16'h0005, V_1111, 1, 1, 16'h0005, V_2222);
        applyStimulus(1, 0, 16'h0005, '0, 1, 0, 16'h0005, '0);
        checkOutput("collision_a", data_out_port_a, V_1111);
        checkOutput("collision_b", data_out_port_b, V_1111);

        $display("[TB] read during write");
        applyStimulus(1, 1, 16'h0007, V_3333, 0, 0, 16'h0000, '0);
        applyStimulus(1, 1, 16'h0007, V_4444, 1, 0, 16'h0007, '0);
        checkOutput("rdw_old_b", data_out_port_b, V_3333);
        applyStimulus(0, 0, 16'h0000, '0, 1, 0, 16'h0007, '0);
        checkOutput("rdw_new_b", data_out_port_b, V_4444);

        $display("[TB] enable hold");
        applyStimulus(1, 0, 16'h0010, '0, 0, 0, 16'h0000, '0);
        checkOutput("hold_start_a", data_out_port_a, V_PATTERN);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 16'h0005 + 16'(i), '0, 0, 0, 16'h0000, '0);
            checkOutput("hold_a", data_out_port_a, V_PATTERN);
        end

        $display("[TB] disabled write");
        applyStimulus(0, 1, 16'h0010, V_DEAD, 0, 1, 16'h0007, V_DEAD);
        applyStimulus(1, 0, 16'h0010, '0, 1, 0, 16'h0007, '0);
        checkOutput("disabled_write_a", data_out_port_a, V_PATTERN);
        checkOutput("disabled_write_b", data_out_port_b, V_4444);

        $display("[TB] concurrent distinct addresses");
        applyStimulus(1, 1, 16'h0100, V_X, 1, 1, 16'h0200, V_Y);
        applyStimulus(1, 0, 16'h0200, '0, 1, 0, 16'h0100, '0);
        checkOutput("concurrent_a", data_out_port_a, V_Y);
        checkOutput("concurrent_b", data_out_port_b, V_X);

        $display("[TB] reset mid-operation");
        applyStimulus(1, 0, 16'h0010, '0, 1, 0, 16'hFFFF, '0);
        checkOutput("pre_reset_a", data_out_port_a, V_PATTERN);
        checkOutput("pre_reset_b", data_out_port_b, V_AAAA);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_a", data_out_port_a, '0);
        checkOutput("async_reset_b", data_out_port_b, '0);
        applyStimulus(1, 1, 16'h0010, V_DEAD, 1, 0, 16'hFFFF, '0);
        checkOutput("in_reset_a", data_out_port_a, '0);
        checkOutput("in_reset_b", data_out_port_b, '0);
        rst_n = 1'b1;
        applyStimulus(1, 1, 16'h0020, V_W, 0, 0, 16'h0000, '0);
        applyStimulus(1, 0, 16'h0010, '0, 0, 0, 16'h0000, '0);
        checkOutput("reset_write_ignored", data_out_port_a, V_PATTERN);
        applyStimulus(1, 0, 16'h0020, '0, 0, 0, 16'h0000, '0);
        checkOutput("post_reset_read", data_out_port_a, V_W);
        checkOutput("post_reset_b_zero", data_out_port_b, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
